// File: rtl/mic_frame_pingpong_writer.sv
// Serialises multi-channel mic samples into two ping-pong RAM banks through the s2 port,
// prefixing each completed bank with a {seq, FRAME_LEN} header and flagging it to the host.
module mic_frame_pingpong_writer #(
  parameter int NUM_CH    = 8,
  parameter int SAMPLE_W  = 24,
  parameter int ADDR_W    = 10,
  parameter int FRAME_LEN = 63
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset_n,
  input  logic                         enable,
  input  logic                         in_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0]   in_data,
  output logic                         in_ready,
  output logic [ADDR_W-1:0]            ram_address,
  output logic                         ram_chipselect,
  output logic                         ram_clken,
  output logic                         ram_write,
  output logic [31:0]                  ram_writedata,
  output logic [3:0]                   ram_byteenable,
  output logic [1:0]                   frame_ready,
  input  logic [1:0]                   frame_ack,
  output logic                         irq,
  output logic [15:0]                  overflow_count
);

  localparam int BANK_WORDS = 2 ** (ADDR_W - 1);
  localparam int OFS_W      = ADDR_W - 1;
  localparam int C_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int S_W        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  generate
    if (1 + NUM_CH * FRAME_LEN > BANK_WORDS) begin : g_size_check
      $error("frame (header + NUM_CH*FRAME_LEN words) does not fit in one bank");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_HDR, ST_WAIT_BANK} state_t;

  state_t                      state_reg, state_next;
  logic                        active_reg, active_next;
  logic [C_W-1:0]              ch_idx_reg, ch_idx_next;
  logic [S_W-1:0]              sample_idx_reg, sample_idx_next;
  logic [OFS_W-1:0]            word_ptr_reg, word_ptr_next;
  logic [15:0]                 seq_reg, seq_next;
  logic [1:0]                  frame_ready_reg, frame_ready_next;
  logic [15:0]                 overflow_reg, overflow_next;
  logic [NUM_CH*SAMPLE_W-1:0]  data_reg;
  logic                        latch_en;
  logic [1:0]                  set_mask;
  logic                        bank_free;
  logic [NUM_CH-1:0][31:0]     ext_words;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ext
      assign ext_words[gi] = 32'($signed(data_reg[gi*SAMPLE_W +: SAMPLE_W]));
    end
  endgenerate

  // An ack landing in the same cycle as the check counts as a free bank.
  assign bank_free = !frame_ready_reg[~active_reg] || frame_ack[~active_reg];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg       <= ST_IDLE;
      active_reg      <= 1'b0;
      ch_idx_reg      <= '0;
      sample_idx_reg  <= '0;
      word_ptr_reg    <= OFS_W'(1);
      seq_reg         <= '0;
      frame_ready_reg <= '0;
      overflow_reg    <= '0;
      data_reg        <= '0;
    end else begin
      state_reg       <= state_next;
      active_reg      <= active_next;
      ch_idx_reg      <= ch_idx_next;
      sample_idx_reg  <= sample_idx_next;
      word_ptr_reg    <= word_ptr_next;
      seq_reg         <= seq_next;
      frame_ready_reg <= frame_ready_next;
      overflow_reg    <= overflow_next;
      if (latch_en) data_reg <= in_data;
    end
  end

  always_comb begin
    state_next      = state_reg;
    active_next     = active_reg;
    ch_idx_next     = ch_idx_reg;
    sample_idx_next = sample_idx_reg;
    word_ptr_next   = word_ptr_reg;
    seq_next        = seq_reg;
    latch_en        = 1'b0;
    set_mask        = '0;
    in_ready        = 1'b0;
    ram_chipselect  = 1'b0;
    ram_clken       = 1'b0;
    ram_write       = 1'b0;
    ram_address     = '0;
    ram_writedata   = '0;
    ram_byteenable  = '0;

    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && enable) begin
          latch_en    = 1'b1;
          ch_idx_next = '0;
          state_next  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        ram_chipselect = 1'b1;
        ram_clken      = 1'b1;
        ram_write      = 1'b1;
        ram_byteenable = 4'hF;
        ram_address    = {active_reg, word_ptr_reg};
        ram_writedata  = ext_words[ch_idx_reg];
        word_ptr_next  = word_ptr_reg + OFS_W'(1);
        if (ch_idx_reg == C_W'(NUM_CH - 1)) begin
          if (sample_idx_reg < S_W'(FRAME_LEN - 1)) begin
            sample_idx_next = sample_idx_reg + S_W'(1);
            state_next      = ST_IDLE;
          end else begin
            state_next = ST_HDR;
          end
        end else begin
          ch_idx_next = ch_idx_reg + C_W'(1);
        end
      end
      ST_HDR: begin
        ram_chipselect       = 1'b1;
        ram_clken            = 1'b1;
        ram_write            = 1'b1;
        ram_byteenable       = 4'hF;
        ram_address          = {active_reg, OFS_W'(0)};
        ram_writedata        = {seq_reg, 16'(FRAME_LEN)};
        set_mask[active_reg] = 1'b1;
        seq_next             = seq_reg + 16'd1;
        sample_idx_next      = '0;
        word_ptr_next        = OFS_W'(1);
        if (bank_free) begin
          active_next = ~active_reg;
          state_next  = ST_IDLE;
        end else begin
          state_next = ST_WAIT_BANK;
        end
      end
      ST_WAIT_BANK: begin
        if (bank_free) begin
          active_next = ~active_reg;
          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Set wins over a same-cycle ack on the same bit.
    frame_ready_next = (frame_ready_reg & ~frame_ack) | set_mask;

    overflow_next = overflow_reg;
    if (in_valid && enable && !in_ready && overflow_reg != 16'hFFFF)
      overflow_next = overflow_reg + 16'd1;
  end

  assign frame_ready    = frame_ready_reg;
  assign irq            = |frame_ready_reg;
  assign overflow_count = overflow_reg;

endmodule

// File: tb/tb_mic_frame_pingpong_writer.sv
// Directed-vector bench for mic_frame_pingpong_writer with NUM_CH=4, FRAME_LEN=2, ADDR_W=10.
module tb_mic_frame_pingpong_writer;

  localparam int NUM_CH = 4, SAMPLE_W = 24, ADDR_W = 10, FRAME_LEN = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, in_valid, in_ready;
  logic [95:0] in_data;
  logic [9:0]  ram_address;
  logic        ram_chipselect, ram_clken, ram_write;
  logic [31:0] ram_writedata;
  logic [3:0]  ram_byteenable;
  logic [1:0]  frame_ready, frame_ack;
  logic        irq;
  logic [15:0] overflow_count;

  always #5 clk = ~clk;

  mic_frame_pingpong_writer #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .ram_address(ram_address),
    .ram_chipselect(ram_chipselect), .ram_clken(ram_clken), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_byteenable(ram_byteenable),
    .frame_ready(frame_ready), .frame_ack(frame_ack), .irq(irq),
    .overflow_count(overflow_count)
  );

  logic [31:0] mem [1024];
  always @(posedge clk) if (ram_write) mem[ram_address] <= ram_writedata;

  typedef struct {
    logic        vld, en;
    logic [1:0]  ack;
    logic [95:0] d;
    logic        rdy, wr;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic [1:0]  fr;
    logic [15:0] ovf;
  } vec_t;

  vec_t vecs[$];
  int   vec_count = 0;
  int   miss_count = 0;

  function automatic void add(logic vld, logic en, logic [1:0] ack, logic [95:0] d, logic rdy,
                              logic wr, logic [9:0] addr, logic [31:0] wd, logic [1:0] fr,
                              logic [15:0] ovf);
    vec_t t;
    t.vld = vld; t.en = en; t.ack = ack; t.d = d; t.rdy = rdy; t.wr = wr;
    t.addr = addr; t.wd = wd; t.fr = fr; t.ovf = ovf;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic rdy, input logic wr, input logic [9:0] addr,
                          input logic [31:0] wd, input logic [1:0] fr, input logic [15:0] ovf);
    chk({tag, " in_ready"}, 32'(in_ready), 32'(rdy));
    chk({tag, " write"}, 32'(ram_write), 32'(wr));
    chk({tag, " chipselect"}, 32'(ram_chipselect), 32'(wr));
    chk({tag, " clken"}, 32'(ram_clken), 32'(wr));
    chk({tag, " byteenable"}, 32'(ram_byteenable), wr ? 32'hF : 32'h0);
    chk({tag, " address"}, 32'(ram_address), 32'(addr));
    chk({tag, " writedata"}, ram_writedata, wd);
    chk({tag, " frame_ready"}, 32'(frame_ready), 32'(fr));
    chk({tag, " irq"}, 32'(irq), 32'(|fr));
    chk({tag, " overflow"}, 32'(overflow_count), 32'(ovf));
  endtask

  initial begin
    logic [95:0] d1234, dsgn, djunk;
    bit          found;
    d1234 = {24'd4, 24'd3, 24'd2, 24'd1};
    dsgn  = {24'hFFFFFE, 24'h000010, 24'h7FFFFF, 24'h800001};
    djunk = {4{24'h123456}};

    //  vld en ack  data                                 rdy wr addr  wdata          fr     ovf
    add(1, 1, 2'b00, d1234,                              1, 0, 10'd0,   32'h0,        2'b00, 16'd0); // 0
    add(0, 1, 2'b00, '0,                                 0, 1, 10'd1,   32'd1,        2'b00, 16'd0);
    add(0, 1, 2'b00, '0,                                 0, 1, 10'd2,   32'd2,        2'b00, 16'd0);
    add(0, 1, 2'b00, '0,                                 0, 1, 10'd3,   32'd3,        2'b00, 16'd0);
    add(0, 1, 2'b01, '0,                                 0, 1, 10'd4,   32'd4,        2'b00, 16'd0);
    add(1, 1, 2'b00, dsgn,                               1, 0, 10'd0,   32'h0,        2'b00, 16'd0); // 5
    add(1, 1, 2'b00, djunk,                              0, 1, 10'd5,   32'hFF800001, 2'b00, 16'd0);
    add(0, 1, 2'b00, '0,                                 0, 1, 10'd6,   32'h007FFFFF, 2'b00, 16'd1);
    add(0, 1, 2'b00, '0,                                 0, 1, 10'd7,   32'h00000010, 2'b00, 16'd1);
    add(0, 1, 2'b00, '0,                                 0, 1, 10'd8,   32'hFFFFFFFE, 2'b00, 16'd1);
    add(0, 1, 2'b00, '0,                                 0, 1, 10'd0,   32'h00000002, 2'b00, 16'd1); // 10 hdr0
    add(1, 1, 2'b00, {24'd8, 24'd7, 24'd6, 24'd5},       1, 0, 10'd0,   32'h0,        2'b01, 16'd1);
    add(0, 1, 2'b00, '0,                                 0, 1, 10'd513, 32'd5,        2'b01, 16'd1);
    add(0, 1, 2'b00, '0,                                 0, 1, 10'd514, 32'd6,        2'b01, 16'd1);
    add(0, 1, 2'b00, '0,                                 0, 1, 10'd515, 32'd7,        2'b01, 16'd1);
    add(0, 1, 2'b00, '0,                                 0, 1, 10'd516, 32'd8,        2'b01, 16'd1); // 15
    add(1, 1, 2'b00, {24'd12, 24'd11, 24'd10, 24'd9},    1, 0, 10'd0,   32'h0,        2'b01, 16'd1);
    add(0, 1, 2'b00, '0,                                 0, 1, 10'd517, 32'd9,        2'b01, 16'd1);
    add(0, 1, 2'b00, '0,                                 0, 1, 10'd518, 32'd10,       2'b01, 16'd1);
    add(0, 1, 2'b00, '0,                                 0, 1, 10'd519, 32'd11,       2'b01, 16'd1);
    add(0, 1, 2'b00, '0,                                 0, 1, 10'd520, 32'd12,       2'b01, 16'd1); // 20
    add(0, 1, 2'b10, '0,                                 0, 1, 10'd512, 32'h00010002, 2'b01, 16'd1); // hdr1, ack same bit
    add(1, 1, 2'b00, d1234,                              0, 0, 10'd0,   32'h0,        2'b11, 16'd1); // wait bank
    add(0, 1, 2'b00, '0,                                 0, 0, 10'd0,   32'h0,        2'b11, 16'd2);
    add(1, 1, 2'b00, d1234,                              0, 0, 10'd0,   32'h0,        2'b11, 16'd2);
    add(0, 1, 2'b01, '0,                                 0, 0, 10'd0,   32'h0,        2'b11, 16'd3); // 25 ack bank0
    add(1, 1, 2'b00, {24'd16, 24'd15, 24'd14, 24'd13},   1, 0, 10'd0,   32'h0,        2'b10, 16'd3);
    add(0, 1, 2'b00, '0,                                 0, 1, 10'd1,   32'd13,       2'b10, 16'd3);
    add(0, 1, 2'b00, '0,                                 0, 1, 10'd2,   32'd14,       2'b10, 16'd3);
    add(0, 1, 2'b00, '0,                                 0, 1, 10'd3,   32'd15,       2'b10, 16'd3);
    add(0, 1, 2'b00, '0,                                 0, 1, 10'd4,   32'd16,       2'b10, 16'd3); // 30
    add(1, 0, 2'b00, d1234,                              1, 0, 10'd0,   32'h0,        2'b10, 16'd3); // disabled strobe
    add(1, 1, 2'b00, {24'd20, 24'd19, 24'd18, 24'd17},   1, 0, 10'd0,   32'h0,        2'b10, 16'd3);
    add(1, 0, 2'b00, djunk,                              0, 1, 10'd5,   32'd17,       2'b10, 16'd3);
    add(0, 1, 2'b00, '0,                                 0, 1, 10'd6,   32'd18,       2'b10, 16'd3);

    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0; frame_ack = '0;
    repeat (3) @(negedge clk);
    chk_outs("reset", 1'b1, 1'b0, 10'd0, 32'h0, 2'b00, 16'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      in_valid = vecs[i].vld; enable = vecs[i].en; frame_ack = vecs[i].ack; in_data = vecs[i].d;
      chk_outs($sformatf("v%0d", i), vecs[i].rdy, vecs[i].wr, vecs[i].addr, vecs[i].wd,
               vecs[i].fr, vecs[i].ovf);
      $display("vector %0d: addr=%0d wdata=%h fr=%b ovf=%0d", i, ram_address, ram_writedata,
               frame_ready, overflow_count);
    end

    // Reset in the middle of a channel burst
    @(negedge clk);
    in_valid = 1'b0; enable = 1'b1; frame_ack = '0;
    chk_outs("pre_reset", 1'b0, 1'b1, 10'd7, 32'd19, 2'b10, 16'd3);
    #1 rst_n = 1'b0;
    #1 chk_outs("mid_reset", 1'b1, 1'b0, 10'd0, 32'h0, 2'b00, 16'd0);
    $display("mid-write reset: addr=%0d write=%b", ram_address, ram_write);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_data = d1234;
    @(negedge clk);
    in_valid = 1'b0;
    chk_outs("restart_ch0", 1'b0, 1'b1, 10'd1, 32'd1, 2'b00, 16'd0);
    $display("restart: addr=%0d wdata=%h", ram_address, ram_writedata);

    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (in_ready) found = 1'b1;
    end
    if (!found) begin
      vec_count++; miss_count++;
      $display("FAIL restart_ready: got in_ready=0 for 10 cycles, expected 1");
    end
    in_valid = 1'b1; in_data = {24'd8, 24'd7, 24'd6, 24'd5};
    @(negedge clk);
    in_valid = 1'b0;

    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (ram_write && ram_address == 10'd0) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) begin
      vec_count++; miss_count++;
      $display("FAIL restart_hdr: got no header write in 20 cycles, expected one at addr 0");
    end else begin
      chk("restart_hdr seq0", ram_writedata, 32'h00000002);
      $display("restart header: wdata=%h", ram_writedata);
    end
    @(negedge clk);
    chk("restart frame_ready", 32'(frame_ready), 32'h1);
    chk("restart irq", 32'(irq), 32'h1);

    chk("mem[1]", mem[1], 32'd1);
    chk("mem[4]", mem[4], 32'd4);
    chk("mem[7]", mem[7], 32'd7);
    chk("mem[8]", mem[8], 32'd8);
    chk("mem[512]", mem[512], 32'h00010002);
    chk("mem[516]", mem[516], 32'd8);
    chk("mem[520]", mem[520], 32'd12);
    $display("ram image: mem[0]=%h mem[512]=%h", mem[0], mem[512]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
